// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG DCT transpose path.
package jpeg_pkg;

  localparam int DIN_W  = 16;
  localparam int SAMP_W = 12;
  localparam int N      = 8;
  localparam int ROW_W  = 96;

  typedef logic signed [SAMP_W-1:0] samp_t;
  typedef logic [ROW_W-1:0]         row_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_t;

endpackage

// File: rtl/sat_trunc.sv
// DIN_W -> SAMP_W sample conversion for the row packer.
// Build option: ROW_PACKER_SAT_EN selects signed saturation; otherwise the
// low SAMP_W bits are kept. Purely combinational, so the packer latency is
// identical in both builds.
module sat_trunc #(
  parameter int DIN_W  = 16,
  parameter int SAMP_W = 12
) (
  input  logic [DIN_W-1:0]  din,
  output logic [SAMP_W-1:0] dout
);

`ifdef ROW_PACKER_SAT_EN
  // Bits above the target sign bit must all match it for the value to fit.
  logic [DIN_W-SAMP_W:0] hi;
  logic                  fits;

  assign hi   = din[DIN_W-1:SAMP_W-1];
  assign fits = (&hi) | (~|hi);

  // Clamp to the most positive / most negative SAMP_W code when out of range.
  always_comb begin
    dout = din[SAMP_W-1:0];
    if (!fits) begin
      if (din[DIN_W-1]) dout = {1'b1, {(SAMP_W-1){1'b0}}};
      else              dout = {1'b0, {(SAMP_W-1){1'b1}}};
    end
  end
`else
  // Upper bits are intentionally dropped in the truncating build.
  logic unused_hi;

  assign unused_hi = ^din[DIN_W-1:SAMP_W];
  assign dout      = din[SAMP_W-1:0];
`endif

endmodule

// File: rtl/row_packer.sv
// row_packer: packs serial row-DCT coefficients into 96-bit transpose rows.
// Eight samples form one row (first sample in the MSBs), eight rows form a
// block. A block only starts when the transpose memory reports empty.
// Build option: ROW_PACKER_SAT_EN (saturate instead of truncate, in sat_trunc).
module row_packer
  import jpeg_pkg::*;
#(
  parameter int DIN_W  = jpeg_pkg::DIN_W,
  parameter int SAMP_W = jpeg_pkg::SAMP_W,
  parameter int N      = jpeg_pkg::N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DIN_W-1:0] in_data,
  output logic             in_ready,
  input  logic             tp_empty,
  output logic             wr,
  output row_t             row,
  output logic             blk_done
);

  localparam int CW   = $clog2(N);
  localparam int SH_W = (N-1)*SAMP_W;

  if (N*SAMP_W != ROW_W) begin : g_bad_geom
    $error("row_packer: N*SAMP_W must equal ROW_W");
  end

  pack_state_t       state, state_n;
  logic [CW-1:0]     scnt, rcnt;
  logic [SH_W-1:0]   shreg;
  logic [SAMP_W-1:0] samp;
  logic              accept, last_samp, last_row;

  sat_trunc #(
    .DIN_W (DIN_W),
    .SAMP_W(SAMP_W)
  ) u_conv (
    .din (in_data),
    .dout(samp)
  );

  assign in_ready  = (state == FILL);
  assign accept    = in_valid & in_ready;
  assign last_samp = (scnt == CW'(N-1));
  assign last_row  = (rcnt == CW'(N-1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state: tp_empty is only looked at in IDLE; a block runs to completion.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tp_empty) state_n = FILL;
      FILL:    if (accept && last_samp && last_row) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sample / row counters; held at zero whenever no block is open.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      scnt <= '0;
      rcnt <= '0;
    end else if (accept) begin
      scnt <= scnt + 1'b1;
      if (last_samp) rcnt <= rcnt + 1'b1;
    end
  end

  // Shift register holds the first N-1 samples of the row being collected.
  always_ff @(posedge clk) begin
    if (rst)         shreg <= '0;
    else if (accept) shreg <= {shreg[SH_W-SAMP_W-1:0], samp};
  end

  // Completed row goes out one cycle after its last sample; row holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      wr       <= 1'b0;
      blk_done <= 1'b0;
    end else begin
      wr       <= accept & last_samp;
      blk_done <= accept & last_samp & last_row;
      if (accept && last_samp) row <= {shreg, samp};
    end
  end

endmodule

// File: tb/tb_row_packer.sv
// Self-checking bench for row_packer: a behavioural model pushes expected
// rows into a scoreboard on each accepted 8th sample, and every wr pops one.
module tb_row_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        tp_empty;
  logic        wr;
  logic [95:0] row;
  logic        blk_done;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit          m_fill;
  int          m_bcnt, m_scnt, m_rcnt;
  logic [95:0] m_acc;
  logic [96:0] sb[$];
  logic [15:0] blk_data[64];

  always #5 clk = ~clk;

  row_packer dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .tp_empty(tp_empty),
    .wr      (wr),
    .row     (row),
    .blk_done(blk_done)
  );

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] conv(input logic [15:0] d);
`ifdef ROW_PACKER_SAT_EN
    int v;
    v = int'($signed(d));
    if (v > 2047)  return 12'h7FF;
    if (v < -2048) return 12'h800;
    return d[11:0];
`else
    return d[11:0];
`endif
  endfunction

  // One clock: drive, update model at the edge, check outputs just after.
  task automatic step(input logic v, input logic [15:0] d, output bit acc);
    logic [96:0] e;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    acc = 0;
    if (rst) begin
      m_fill = 0; m_bcnt = 0; m_scnt = 0; m_rcnt = 0;
    end else if (!m_fill) begin
      m_fill = tp_empty;
    end else if (v) begin
      acc   = 1;
      m_acc = {m_acc[83:0], conv(d)};
      m_bcnt++;
      m_scnt++;
      if (m_scnt == 8) begin
        sb.push_back({(m_rcnt == 7), m_acc});
        m_scnt = 0;
        m_rcnt++;
      end
      if (m_bcnt == 64) begin
        m_fill = 0; m_bcnt = 0; m_rcnt = 0;
      end
    end
    #1;
    chk("in_ready", in_ready, m_fill);
    chk("wr", wr, sb.size() != 0);
    if (wr && sb.size() != 0) begin
      e = sb.pop_front();
      chk("row", row, e[95:0]);
      chk("blk_done", blk_done, e[96]);
    end else begin
      chk("blk_done_nowr", blk_done, 1'b0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Push one 64-sample block; mode 1 alternates in_valid. Returns cycles used.
  task automatic send_block(input int mode, output int cycles);
    int i = 0;
    bit acc;
    bit v;
    cycles = 0;
    while (i < 64 && cycles < 400) begin
      v = (mode == 1) ? (cycles % 2 == 0) : 1'b1;
      step(v, v ? blk_data[i] : 16'hDEAD, acc);
      if (acc) i++;
      cycles++;
    end
    chk("block_done_in_budget", 96'(i), 96'd64);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int cyc;
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; tp_empty = 1'b0;
    @(negedge clk);

    // reset state
    step(0, 0, acc);
    step(1, 16'h1234, acc);
    chk("rst_row", row, 96'd0);
    rst = 1'b0;
    repeat (3) step(1, 16'h0055, acc);

    // single block, ramp 0..63
    tp_empty = 1'b1;
    for (int i = 0; i < 64; i++) blk_data[i] = 16'(i);
    send_block(0, cyc);
    chk("ramp_cycles", 96'(cyc), 96'd65);

    // backpressure: no new block while tp_empty low
    tp_empty = 1'b0;
    repeat (20) step(1, 16'h0777, acc);
    tp_empty = 1'b1;
    for (int i = 0; i < 64; i++) blk_data[i] = 16'($urandom);
    send_block(1, cyc);

    // back-to-back block with saturation boundary values up front
    blk_data[0] = 16'h1000; blk_data[1] = 16'hE000;
    blk_data[2] = 16'h07FF; blk_data[3] = 16'hF800;
    blk_data[4] = 16'h0800; blk_data[5] = 16'hF7FF;
    blk_data[6] = 16'h7FFF; blk_data[7] = 16'h8000;
    for (int i = 8; i < 64; i++) blk_data[i] = 16'($urandom);
    send_block(0, cyc);
    chk("b2b_cycles", 96'(cyc), 96'd65);

    // reset mid-row: 5 accepts, then reset discards them
    k = 0;
    while (k < 5 && cyc < 500) begin
      step(1, 16'h0100 + 16'(k), acc);
      if (acc) k++;
      cyc++;
    end
    rst = 1'b1;
    step(1, 16'h0FFF, acc);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) blk_data[i] = 16'(200 + i);
    send_block(0, cyc);

    // trailing idle cycles: nothing further may be written
    tp_empty = 1'b0;
    repeat (4) step(0, 0, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
